branch_redirect: RTL
====================

BRANCH_REDIRECT -- requirements
Module: branch_redirect

Interface
REQ-001 SHALL have parameter UPD_DEPTH, default 4, predictor-update FIFO depth (power of 2, >=2).
REQ-002 SHALL have parameter CNT_W, default 16, dropped-update counter width.
REQ-003 SHALL have ports clk input 1, the single clock; rst_n input 1, reset that is asynchronous and active-low.
REQ-004 SHALL have port stall input 1; when high, the resolved_branch inputs are ignored.
REQ-005 SHALL have ports resolved_branch_0 and resolved_branch_1, each input of type branch_resolved_t; slot 0 is older than slot 1. Fields used: valid, mispredict, taken, pc[31:0], target[31:0].
REQ-006 SHALL have port flush output 1, a one-cycle pipeline flush pulse.
REQ-007 SHALL have ports redirect_valid output 1 and redirect_pc output 32, the frontend redirect request.
REQ-008 SHALL have port redirect_ack input 1; the frontend accepts the redirect when redirect_ack and redirect_valid are both high.
REQ-009 SHALL have ports upd_valid output 1, upd_pc output 32, upd_target output 32 and upd_taken output 1, forming the predictor-update head.
REQ-010 SHALL have port upd_ready input 1; a pop occurs when upd_valid and upd_ready are both high.
REQ-011 SHALL have port drop_cnt output CNT_W, the count of updates lost because the FIFO was full.

Function
REQ-012 SHALL implement FSM states IDLE and REDIRECT.
REQ-013 SHALL sample a slot only when all of the following hold: state is IDLE, stall is 0, and the slot's valid is 1.
REQ-014 SHALL treat slot 1 as wrong-path and discard it (no push, no redirect) when sampled slot 0 has mispredict=1.
REQ-015 SHALL select the oldest sampled mispredicting slot as the mispredicted branch.
REQ-016 SHALL compute correct PC = target when taken=1, else pc+8 (delay slot), with the addition modulo 2^32.
REQ-017 SHALL, on a mispredict in IDLE, do the following in the next cycle: pulse flush high for exactly 1 cycle, register redirect_pc, assert redirect_valid, and enter REDIRECT.
REQ-018 SHALL hold redirect_valid and redirect_pc stable in REDIRECT until redirect_ack; return to IDLE the cycle after acceptance.
REQ-019 SHALL ignore all resolved_branch inputs while in REDIRECT, including the accepting cycle, since they are wrong-path.
REQ-020 SHALL push every sampled, non-discarded slot into the update FIFO, slot 0 before slot 1, whether or not it mispredicted; the entry is {pc, target, taken}.
REQ-021 SHALL push at most 2 entries per cycle.
REQ-022 SHALL compute free space as UPD_DEPTH minus occupancy plus 1 if a pop occurs in the same cycle.
REQ-023 SHALL push in order while space remains; each push that does not fit is dropped and increments drop_cnt.
REQ-024 SHALL saturate drop_cnt at all-ones.
REQ-025 SHALL drive upd_valid = FIFO non-empty and upd_* = head entry, with zero-cycle output from the FIFO.
REQ-026 SHALL permit simultaneous push and pop when full; occupancy then stays constant.
REQ-027 SHALL wrap the FIFO pointers modulo UPD_DEPTH.
REQ-028 SHALL track empty and full with an occupancy counter of width log2(UPD_DEPTH)+1.
REQ-029 SHALL NOT stall or flush the pipeline because the update FIFO is full.

Reset
REQ-030 SHALL, on rst_n low at any time including mid-REDIRECT, immediately do the following: enter state IDLE, empty the FIFO, and clear flush, redirect_valid, redirect_pc, upd_valid, upd_pc, upd_target, upd_taken and drop_cnt to 0.
REQ-031 SHALL, after rst_n rises, begin sampling on the first clk edge.

Verification
REQ-032 SHALL cover this scenario: slot0 {valid=1, mispredict=1, taken=1, pc=0x80000100, target=0x80000200}, redirect_ack=1 -> next cycle flush=1, redirect_valid=1, redirect_pc=0x80000200; one FIFO entry; IDLE the cycle after.
REQ-033 SHALL cover this scenario: slot0 mispredict with taken=0, pc=0xFFFFFFFC -> redirect_pc=0x00000004 (wrap-around).
REQ-034 SHALL cover this scenario: both slots valid, slot0 mispredict=1, slot1 mispredict=1 -> redirect to slot0's correct PC, exactly one push, slot1 discarded.
REQ-035 SHALL cover this scenario: redirect_ack held 0 for 5 cycles while slots fire mispredicts -> redirect_pc unchanged, flush pulses once, no pushes.
REQ-036 SHALL cover this scenario: with UPD_DEPTH=4, upd_ready=0, push 5 correct branches -> 4 entries, drop_cnt=1. Then hold upd_ready=1 while pushing 2 per cycle into a full FIFO -> 1 accepted, drop_cnt+1 per cycle.
REQ-037 SHALL cover this scenario: rst_n asserted in REDIRECT with FIFO holding 3 entries -> all outputs 0 before the next clk edge; after release, upd_valid=0.

Source files
------------

// File: rtl/branch_redirect_if.sv
// Shared types and the bundled pipeline/frontend/predictor signal set for
// branch_redirect. The package travels with the interface so both sides agree
// on the resolved-branch record layout.

package branch_redirect_pkg;

    typedef struct packed {
        logic        valid;
        logic        mispredict;
        logic        taken;
        logic [31:0] pc;
        logic [31:0] target;
    } branch_resolved_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic        taken;
    } upd_entry_t;

endpackage

interface branch_redirect_if #(
    parameter int CNT_W = 16
);
    import branch_redirect_pkg::*;

    logic             stall;
    branch_resolved_t resolved_branch_0;
    branch_resolved_t resolved_branch_1;
    logic             flush;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic             redirect_ack;
    logic             upd_valid;
    logic [31:0]      upd_pc;
    logic [31:0]      upd_target;
    logic             upd_taken;
    logic             upd_ready;
    logic [CNT_W-1:0] drop_cnt;

    // Pipeline / frontend / predictor side.
    modport master (
        output stall, resolved_branch_0, resolved_branch_1, redirect_ack, upd_ready,
        input  flush, redirect_valid, redirect_pc, upd_valid, upd_pc, upd_target,
               upd_taken, drop_cnt
    );

    // branch_redirect side.
    modport slave (
        input  stall, resolved_branch_0, resolved_branch_1, redirect_ack, upd_ready,
        output flush, redirect_valid, redirect_pc, upd_valid, upd_pc, upd_target,
               upd_taken, drop_cnt
    );

endinterface

// File: rtl/branch_redirect.sv
// Branch resolution back end: turns the oldest mispredicting resolved branch
// into a one-shot flush plus a held frontend redirect, and queues every
// right-path resolved branch into a small predictor-update FIFO. The FIFO
// never back-pressures the pipeline; updates that do not fit are counted.
// The interface CNT_W must match this module's CNT_W.

module branch_redirect
    import branch_redirect_pkg::*;
#(
    parameter int UPD_DEPTH = 4,
    parameter int CNT_W     = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    branch_redirect_if.slave bus
);

    localparam int AW = $clog2(UPD_DEPTH);
    localparam int OW = AW + 1;
    localparam logic [OW-1:0] DEPTH_C = OW'(UPD_DEPTH);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        REDIRECT = 1'b1
    } state_t;

    state_t           state_q;
    logic             flush_q;
    logic             redirect_valid_q;
    logic [31:0]      redirect_pc_q;
    logic [CNT_W-1:0] drop_cnt_q;

    upd_entry_t       mem_q [UPD_DEPTH];
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [OW-1:0]    occ_q;

    logic             samp0_s;
    logic             samp1_s;
    logic             mis_s;
    logic [31:0]      new_pc_s;
    logic             pop_s;
    logic [OW-1:0]    free_s;
    logic [1:0]       n_req_s;
    logic [1:0]       n_acc_s;
    logic [1:0]       n_drop_s;
    upd_entry_t       e0_s;
    upd_entry_t       e1_s;
    logic [CNT_W:0]   drop_sum_s;
    upd_entry_t       head_s;

    // Architecturally correct fetch address after a resolved branch; pc+8 skips the delay slot.
    function automatic logic [31:0] correct_pc(input branch_resolved_t b);
        return b.taken ? b.target : (b.pc + 32'd8);
    endfunction

    // Decide which slots are sampled this cycle and where a mispredict redirects to.
    always_comb begin
        samp0_s = (state_q == IDLE) && !bus.stall && bus.resolved_branch_0.valid;
        // A mispredicting slot 0 makes the younger slot wrong-path.
        samp1_s = (state_q == IDLE) && !bus.stall && bus.resolved_branch_1.valid &&
                  !(samp0_s && bus.resolved_branch_0.mispredict);
        mis_s   = (samp0_s && bus.resolved_branch_0.mispredict) ||
                  (samp1_s && bus.resolved_branch_1.mispredict);
        if (samp0_s && bus.resolved_branch_0.mispredict) begin
            new_pc_s = correct_pc(bus.resolved_branch_0);
        end else begin
            new_pc_s = correct_pc(bus.resolved_branch_1);
        end
    end

    // FIFO accounting: how many of this cycle's pushes fit and how many are lost.
    always_comb begin
        pop_s   = (occ_q != {OW{1'b0}}) && bus.upd_ready;
        free_s  = DEPTH_C - occ_q + {{AW{1'b0}}, pop_s};
        n_req_s = {1'b0, samp0_s} + {1'b0, samp1_s};
        if (free_s >= OW'(n_req_s)) begin
            n_acc_s = n_req_s;
        end else begin
            n_acc_s = free_s[1:0];
        end
        n_drop_s = n_req_s - n_acc_s;
        // The first push is whichever sampled slot is oldest.
        if (samp0_s) begin
            e0_s = '{pc: bus.resolved_branch_0.pc, target: bus.resolved_branch_0.target,
                     taken: bus.resolved_branch_0.taken};
        end else begin
            e0_s = '{pc: bus.resolved_branch_1.pc, target: bus.resolved_branch_1.target,
                     taken: bus.resolved_branch_1.taken};
        end
        e1_s = '{pc: bus.resolved_branch_1.pc, target: bus.resolved_branch_1.target,
                 taken: bus.resolved_branch_1.taken};
        drop_sum_s = {1'b0, drop_cnt_q} + (CNT_W+1)'(n_drop_s);
    end

    // Redirect FSM with registered flush/redirect outputs; inputs are wrong-path while in REDIRECT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mis_s) begin
                        flush_q          <= 1'b1;
                        redirect_valid_q <= 1'b1;
                        redirect_pc_q    <= new_pc_s;
                        state_q          <= REDIRECT;
                    end else begin
                        flush_q <= 1'b0;
                    end
                end
                REDIRECT: begin
                    flush_q <= 1'b0;
                    if (bus.redirect_ack) begin
                        redirect_valid_q <= 1'b0;
                        state_q          <= IDLE;
                    end else begin
                        redirect_valid_q <= 1'b1;
                    end
                end
                default: begin
                    flush_q          <= 1'b0;
                    redirect_valid_q <= 1'b0;
                    state_q          <= IDLE;
                end
            endcase
        end
    end

    // Update FIFO storage, pointers, occupancy and the saturating drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < UPD_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q   <= {AW{1'b0}};
            wr_ptr_q   <= {AW{1'b0}};
            occ_q      <= {OW{1'b0}};
            drop_cnt_q <= {CNT_W{1'b0}};
        end else begin
            if (n_acc_s != 2'd0) begin
                mem_q[wr_ptr_q] <= e0_s;
            end
            if (n_acc_s == 2'd2) begin
                mem_q[wr_ptr_q + AW'(1)] <= e1_s;
            end
            wr_ptr_q <= wr_ptr_q + AW'(n_acc_s);
            rd_ptr_q <= rd_ptr_q + AW'(pop_s);
            occ_q    <= occ_q + OW'(n_acc_s) - OW'(pop_s);
            if (drop_sum_s[CNT_W]) begin
                drop_cnt_q <= {CNT_W{1'b1}};
            end else begin
                drop_cnt_q <= drop_sum_s[CNT_W-1:0];
            end
        end
    end

    // Head entry is presented combinationally; zeros whenever the FIFO is empty.
    always_comb begin
        head_s = mem_q[rd_ptr_q];
        if (occ_q != {OW{1'b0}}) begin
            bus.upd_valid  = 1'b1;
            bus.upd_pc     = head_s.pc;
            bus.upd_target = head_s.target;
            bus.upd_taken  = head_s.taken;
        end else begin
            bus.upd_valid  = 1'b0;
            bus.upd_pc     = 32'd0;
            bus.upd_target = 32'd0;
            bus.upd_taken  = 1'b0;
        end
    end

    assign bus.flush          = flush_q;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.drop_cnt       = drop_cnt_q;

endmodule
